// File: rtl/dsp_addsub_sched_pkg.sv
// Shared constants for the shared DSP add/sub scheduler and its arithmetic core.
package dsp_addsub_sched_pkg;

  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;
  localparam int   ADDSUB_DEFAULT_LATENCY = 2;
  localparam int   ADDSUB_MAX_REQ = 4;

endpackage

// File: rtl/dsp_addsub_core.sv
// 32-bit add/sub unit: SB_MAC16 in 16+16 cascaded adder mode, or an equivalent
// behavioural pipeline. Input registers exist only when LATENCY is 2.
module dsp_addsub_core
  import dsp_addsub_sched_pkg::*;
#(
  parameter int LATENCY = ADDSUB_DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_i,
  input  logic        sub_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);

`ifdef ICE40_DSP
  // Upper operand (a) sits on C/D, lower operand (b) on A/B: result = a +/- b.
  localparam logic IN_REG = (LATENCY >= 2) ? 1'b1 : 1'b0;
  logic [31:0] mac_o;
  logic        mac_co;
  logic        mac_acco;
  logic        mac_sxo;

  SB_MAC16 #(
    .NEG_TRIGGER(1'b0), .C_REG(IN_REG), .A_REG(IN_REG), .B_REG(IN_REG), .D_REG(IN_REG),
    .TOP_8x8_MULT_REG(1'b0), .BOT_8x8_MULT_REG(1'b0),
    .PIPELINE_16x16_MULT_REG1(1'b0), .PIPELINE_16x16_MULT_REG2(1'b0),
    .TOPOUTPUT_SELECT(2'b01), .TOPADDSUB_LOWERINPUT(2'b00),
    .TOPADDSUB_UPPERINPUT(1'b1), .TOPADDSUB_CARRYSELECT(2'b10),
    .BOTOUTPUT_SELECT(2'b01), .BOTADDSUB_LOWERINPUT(2'b00),
    .BOTADDSUB_UPPERINPUT(1'b1), .BOTADDSUB_CARRYSELECT(2'b00),
    .MODE_8x8(1'b0), .A_SIGNED(1'b0), .B_SIGNED(1'b0)
  ) u_mac (
    .CLK(clk), .CE(ce_i),
    .C(a_i[31:16]), .D(a_i[15:0]), .A(b_i[31:16]), .B(b_i[15:0]),
    .AHOLD(1'b0), .BHOLD(1'b0), .CHOLD(1'b0), .DHOLD(1'b0),
    .IRSTTOP(~rst_n), .IRSTBOT(~rst_n), .ORSTTOP(~rst_n), .ORSTBOT(~rst_n),
    .OLOADTOP(1'b0), .OLOADBOT(1'b0), .ADDSUBTOP(sub_i), .ADDSUBBOT(sub_i),
    .OHOLDTOP(1'b0), .OHOLDBOT(1'b0), .CI(1'b0), .ACCUMCI(1'b0), .SIGNEXTIN(1'b0),
    .O(mac_o), .CO(mac_co), .ACCUMCO(mac_acco), .SIGNEXTOUT(mac_sxo)
  );

  assign sum_o   = mac_o;
  assign carry_o = mac_co;
`else
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        sub_s;
  logic [32:0] sum_c;
  logic [31:0] sum_q;
  logic        carry_q;

  generate
    if (LATENCY >= 2) begin : g_inreg
      logic [31:0] a_q;
      logic [31:0] b_q;
      logic        sub_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
        end else if (ce_i) begin
          a_q   <= a_i;
          b_q   <= b_i;
          sub_q <= sub_i;
        end
      end
      assign a_s   = a_q;
      assign b_s   = b_q;
      assign sub_s = sub_q;
    end else begin : g_noinreg
      assign a_s   = a_i;
      assign b_s   = b_i;
      assign sub_s = sub_i;
    end
  endgenerate

  // Subtract as a + ~b + 1 so bit 32 reads as "no borrow".
  always_comb begin
    if (sub_s == ADDSUB_OP_SUB) begin
      sum_c = {1'b0, a_s} + {1'b0, ~b_s} + 33'd1;
    end else begin
      sum_c = {1'b0, a_s} + {1'b0, b_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (ce_i) begin
      sum_q   <= sum_c[31:0];
      carry_q <= sum_c[32];
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
`endif

endmodule

// File: rtl/dsp_addsub_sched.sv
// Round-robin scheduler sharing one pipelined add/sub core between NUM_REQ
// requesters; requester ids travel alongside the core in a tag pipeline.
module dsp_addsub_sched
  import dsp_addsub_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = ADDSUB_DEFAULT_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_sub,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   stall,
  input  logic                   flush,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_result,
  output logic                   resp_carry,
  output logic                   resp_zero
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    if (gnt_any && rst_n && !stall && !flush) begin
      gnt[gnt_id] = 1'b1;
    end
  end

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  logic [31:0] core_sum;
  logic        core_carry;

  dsp_addsub_core #(.LATENCY(LATENCY)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce_i    (~stall),
    .sub_i   (req_sub[gnt_id]),
    .a_i     (req_a[32*gnt_id +: 32]),
    .b_i     (req_b[32*gnt_id +: 32]),
    .sum_o   (core_sum),
    .carry_o (core_carry)
  );

  logic [LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]    tag_id_q [LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_tag
      logic            in_v;
      logic [ID_W-1:0] in_id;
      if (gi == 0) begin : g_head
        assign in_v  = accept;
        assign in_id = gnt_id;
      end else begin : g_body
        assign in_v  = tag_v_q[gi-1];
        assign in_id = tag_id_q[gi-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_v_q[gi]  <= 1'b0;
          tag_id_q[gi] <= '0;
        end else if (flush) begin
          tag_v_q[gi]  <= 1'b0;
        end else if (!stall) begin
          tag_v_q[gi]  <= in_v;
          tag_id_q[gi] <= in_id;
        end
      end
    end
  endgenerate

  // A flush also discards the op sitting in the last stage this cycle.
  logic        resp_fire;
  logic [31:0] res_q;
  logic        carry_q;
  logic        zero_q;

  assign resp_fire = tag_v_q[LATENCY-1] & ~stall & ~flush;

  always_comb begin
    resp_valid = '0;
    if (resp_fire) resp_valid[tag_id_q[LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (resp_fire) begin
      res_q   <= core_sum;
      carry_q <= core_carry;
      zero_q  <= (core_sum == 32'd0);
    end
  end

  assign resp_result = resp_fire ? core_sum              : res_q;
  assign resp_carry  = resp_fire ? core_carry            : carry_q;
  assign resp_zero   = resp_fire ? (core_sum == 32'd0)   : zero_q;

endmodule

// File: tb/tb_dsp_addsub_sched.sv
// Directed bench for dsp_addsub_sched with a response scoreboard.
module tb_dsp_addsub_sched;

  localparam int NR  = 2;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid, req_sub, req_ready, resp_valid;
  logic [63:0] req_a, req_b;
  logic        stall, flush;
  logic [31:0] resp_result;
  logic        resp_carry, resp_zero;

  dsp_addsub_sched #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .stall(stall),
    .flush(flush), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_carry(resp_carry), .resp_zero(resp_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        c;
    logic        z;
    int          due;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input int due);
    exp_t e;
    logic [32:0] w;
    if (s) begin
      e.res = a - b;
      e.c   = (a >= b);
    end else begin
      w     = {1'b0, a} + {1'b0, b};
      e.res = w[31:0];
      e.c   = w[32];
    end
    e.z   = (e.res == 32'd0);
    e.id  = id;
    e.due = due;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (resp_valid !== 2'b00) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_resp observed resp_valid=%b at cycle %0d expected none", resp_valid, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("resp cycle=%0d id=%b result=%h carry=%b zero=%b", cyc, resp_valid, resp_result,
                 resp_carry, resp_zero);
        chk("resp_id", {30'd0, resp_valid}, {30'd0, e.id});
        chk("resp_result", resp_result, e.res);
        chk("resp_carry", {31'd0, resp_carry}, {31'd0, e.c});
        chk("resp_zero", {31'd0, resp_zero}, {31'd0, e.z});
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic [1:0] s,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input logic st, input logic fl,
                      input logic [1:0] exp_rdy, input int lat, input string name);
    req_valid = v;
    req_sub   = s;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    stall     = st;
    flush     = fl;
    if (fl) sb.delete();
    @(negedge clk);
    $display("step %s cycle=%0d valid=%b stall=%b flush=%b ready=%b", name, cyc, v, st, fl, req_ready);
    chk({name, "_ready"}, {30'd0, req_ready}, {30'd0, exp_rdy});
    if (exp_rdy[0]) sb.push_back(model(2'b01, a0, b0, s[0], cyc + lat));
    if (exp_rdy[1]) sb.push_back(model(2'b10, a1, b1, s[1], cyc + lat));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, LAT, "idle");
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, {30'd0, req_ready}, 32'd0);
    chk({name, "_valid"}, {30'd0, resp_valid}, 32'd0);
    chk({name, "_result"}, resp_result, 32'd0);
    chk({name, "_carry"}, {31'd0, resp_carry}, 32'd0);
    chk({name, "_zero"}, {31'd0, resp_zero}, 32'd0);
  endtask

  initial begin
    req_valid = 2'b11; req_sub = 2'b00; req_a = '1; req_b = '1; stall = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rst_n = 1'b1;

    // 1: basic add on req0
    step(2'b01, 2'b00, 5, 3, 0, 0, 1'b0, 1'b0, 2'b01, LAT, "t1_add");
    idle(3);
    chk("t1_hold_result", resp_result, 32'd8);

    // 2: arithmetic corner cases, one requester at a time
    step(2'b01, 2'b01, 5, 3, 0, 0, 1'b0, 1'b0, 2'b01, LAT, "t2_5m3");
    step(2'b01, 2'b01, 3, 5, 0, 0, 1'b0, 1'b0, 2'b01, LAT, "t2_3m5");
    step(2'b10, 2'b00, 0, 0, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 2'b10, LAT, "t2_wrap");
    step(2'b01, 2'b01, 7, 7, 0, 0, 1'b0, 1'b0, 2'b01, LAT, "t2_7m7");
    idle(3);

    // 3: round-robin alternation from pointer 0
    step(2'b10, 2'b00, 0, 0, 10, 20, 1'b0, 1'b0, 2'b10, LAT, "t3_pre");
    idle(2);
    for (int k = 0; k < 4; k++)
      step(2'b11, k[1:0], 100 + k, k, 200 + k, 1, 1'b0, 1'b0, (k % 2 == 0) ? 2'b01 : 2'b10, LAT, "t3_rr");
    idle(3);

    // 4: three stall cycles stretch latency to 5
    step(2'b01, 2'b00, 32'h1234_0000, 32'h0000_5678, 0, 0, 1'b0, 1'b0, 2'b01, 5, "t4_acc");
    for (int k = 0; k < 3; k++) step(2'b11, 2'b00, 1, 1, 2, 2, 1'b1, 1'b0, 2'b00, LAT, "t4_stall");
    idle(4);

    // 5: flush drops two in-flight ops
    step(2'b11, 2'b00, 11, 12, 21, 22, 1'b0, 1'b0, 2'b10, LAT, "t5_op1");
    step(2'b11, 2'b00, 31, 32, 41, 42, 1'b0, 1'b0, 2'b01, LAT, "t5_op0");
    step(2'b11, 2'b00, 1, 1, 1, 1, 1'b0, 1'b1, 2'b00, LAT, "t5_flush");
    step(2'b01, 2'b01, 50, 8, 0, 0, 1'b0, 1'b0, 2'b01, LAT, "t5_after");
    idle(3);

    // 6: asynchronous reset with ops in flight
    step(2'b11, 2'b00, 61, 62, 71, 72, 1'b0, 1'b0, 2'b10, LAT, "t6_op1");
    step(2'b11, 2'b00, 81, 82, 91, 92, 1'b0, 1'b0, 2'b01, LAT, "t6_op0");
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("t6_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b11, 2'b00, 3, 4, 5, 6, 1'b0, 1'b0, 2'b01, LAT, "t6_post");
    idle(3);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
